// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its entry buffer.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam int unsigned FETCH_BUF_DEPTH = 2;
  localparam logic [1:0]  BUF_FULL        = 2'(FETCH_BUF_DEPTH);
  localparam logic [31:0] PC_STEP         = 32'd4;

  // Word-align a byte address by dropping the two low bits.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of {pc, inst} pairs between the fetch request logic and IF/ID.
// Flush wins over push and pop; a push into a full buffer is taken only with a same-cycle pop.
module fetch_buffer
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t entries [FETCH_BUF_DEPTH];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_pop;
  logic         do_push;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count < BUF_FULL) || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FETCH_BUF_DEPTH; i++) begin
        entries[i] <= '0;
      end
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_entry;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Stale slots are never exposed: an empty buffer presents all zeros.
  assign head_valid = (count != 2'd0);
  assign head       = head_valid ? entries[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, word-aligned imem requests, and a 2-entry output buffer.
// Optional macro FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-redirect flag that stalls fetch.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_rd_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic [31:0] out_inst,
  output logic        fetch_misalign
`else
  output logic [31:0] out_inst
`endif
);

  // Handshake: an entry transfers when out_valid && out_ready at a rising edge. Once raised,
  // out_valid and the head payload hold until that transfer, a redirect, or reset.

  logic [31:0]  pc_q;
  logic [1:0]   buf_count;
  logic         pop;
  logic         push;
  logic         fetch_block;
  fetch_entry_t head;
  fetch_entry_t push_entry;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      misalign_q <= (redirect_pc[1:0] != 2'b00);
    end
  end

  assign fetch_misalign = misalign_q;
  assign fetch_block    = misalign_q;
`else
  assign fetch_block = 1'b0;
`endif

  assign pop  = out_valid && out_ready;
  // rst gates the request so the port reads idle while reset is held.
  assign push = !rst && !redirect_valid && !fetch_block && ((buf_count < BUF_FULL) || pop);

  assign imem_rd_en = push;
  assign imem_addr  = pc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= align_word(redirect_pc);
    end else if (push) begin
      pc_q <= pc_q + PC_STEP;
    end
  end

  assign push_entry.pc   = pc_q;
  assign push_entry.inst = imem_inst;

  fetch_buffer u_buf (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect_valid),
    .head       (head),
    .head_valid (out_valid),
    .count      (buf_count)
  );

  assign out_pc   = head.pc;
  assign out_inst = head.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized run against a queue model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_rd_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int errors = 0;
  int checks = 0;
  logic [63:0] exp_q[$];

  fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
`ifdef FETCH_MISALIGN_CHECK_EN
    .out_inst       (out_inst),
    .fetch_misalign (fetch_misalign)
`else
    .out_inst       (out_inst)
`endif
  );

  // Clock / reset block
  always #5 clk = ~clk;

  // Instruction memory: 0x11, 0x22, 0x33 at the first three words, hashed content elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd12) return ((a >> 2) + 32'd1) * 32'h11;
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  always_comb imem_inst = mem_word(imem_addr);

  // Driver tasks
  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset(input logic ready);
    @(negedge clk);
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = ready;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", out_pc); end
    checks++; if (out_inst !== 32'h0) begin errors++; $display("FAIL reset_inst: got %h expected 0", out_inst); end
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", imem_rd_en); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
`ifdef FETCH_MISALIGN_CHECK_EN
    checks++; if (fetch_misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign: got %b expected 0", fetch_misalign); end
`endif
  endtask

  task automatic test_stream();
    apply_reset(1'b1);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_c0_valid: got %b expected 0", out_valid); end
    checks++; if (imem_rd_en !== 1'b1) begin errors++; $display("FAIL stream_c0_rd_en: got %b expected 1", imem_rd_en); end
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d]: got %b expected 1", k, out_valid); end
      checks++; if (out_pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d]: got %h expected %h", k, out_pc, 32'(4 * k)); end
      checks++; if (out_inst !== 32'((k + 1) * 32'h11)) begin errors++; $display("FAIL stream_inst[%0d]: got %h expected %h", k, out_inst, 32'((k + 1) * 32'h11)); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset(1'b0);
    next_cycle();
    next_cycle();
    for (int s = 0; s < 3; s++) begin
      #1;
      checks++; if (dut.buf_count !== 2'd2) begin errors++; $display("FAIL stall_count[%0d]: got %0d expected 2", s, dut.buf_count); end
      checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL stall_rd_en[%0d]: got %b expected 0", s, imem_rd_en); end
      checks++; if (imem_addr !== 32'h8) begin errors++; $display("FAIL stall_pc[%0d]: got %h expected 8", s, imem_addr); end
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL stall_head[%0d]: got v=%b pc=%h expected v=1 pc=0", s, out_valid, out_pc); end
      next_cycle();
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * k) || out_inst !== mem_word(32'(4 * k))) begin
        errors++; $display("FAIL drain[%0d]: got v=%b pc=%h inst=%h expected pc=%h inst=%h", k, out_valid, out_pc, out_inst, 32'(4 * k), mem_word(32'(4 * k)));
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect_ready();
    apply_reset(1'b0);
    next_cycle();
    next_cycle();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    #1;
    checks++; if (imem_rd_en !== 1'b0) begin errors++; $display("FAIL redir_rd_en: got %b expected 0", imem_rd_en); end
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL redir_n1_valid: got %b expected 0", out_valid); end
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_n1_fetch: got en=%b addr=%h expected en=1 addr=100", imem_rd_en, imem_addr); end
    next_cycle();
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== mem_word(32'h100)) begin
      errors++; $display("FAIL redir_n2_head: got v=%b pc=%h inst=%h expected pc=100 inst=%h", out_valid, out_pc, out_inst, mem_word(32'h100));
    end
  endtask

  task automatic test_wrap();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr: got %h expected fffffffc", imem_addr); end
    next_cycle();
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head0: got v=%b pc=%h expected pc=fffffffc", out_valid, out_pc); end
    next_cycle();
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h11) begin errors++; $display("FAIL wrap_head1: got v=%b pc=%h inst=%h expected pc=0 inst=11", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_async_reset();
    apply_reset(1'b0);
    next_cycle();
    next_cycle();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || imem_rd_en !== 1'b0) begin errors++; $display("FAIL arst_ctrl: got v=%b en=%b expected 0 0", out_valid, imem_rd_en); end
    checks++; if (out_pc !== 32'h0 || out_inst !== 32'h0) begin errors++; $display("FAIL arst_data: got pc=%h inst=%h expected 0 0", out_pc, out_inst); end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    checks++; if (imem_rd_en !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL arst_restart: got en=%b addr=%h expected en=1 addr=0", imem_rd_en, imem_addr); end
    next_cycle();
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_inst !== 32'h11) begin errors++; $display("FAIL arst_first: got v=%b pc=%h inst=%h expected pc=0 inst=11", out_valid, out_pc, out_inst); end
  endtask

  task automatic test_misalign();
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    next_cycle();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    #1;
    checks++; if (fetch_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag_set: got %b expected 1", fetch_misalign); end
    for (int s = 0; s < 4; s++) begin
      #1;
      checks++; if (imem_rd_en !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL mis_stall[%0d]: got en=%b v=%b expected 0 0", s, imem_rd_en, out_valid); end
      next_cycle();
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    checks++; if (fetch_misalign !== 1'b0 || imem_rd_en !== 1'b1) begin errors++; $display("FAIL mis_clear: got flag=%b en=%b expected 0 1", fetch_misalign, imem_rd_en); end
    next_cycle();
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h200) begin errors++; $display("FAIL mis_resume: got v=%b pc=%h expected pc=200", out_valid, out_pc); end
`else
    next_cycle();
    #1;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_inst !== mem_word(32'h100)) begin
      errors++; $display("FAIL mis_truncate: got v=%b pc=%h inst=%h expected pc=100 inst=%h", out_valid, out_pc, out_inst, mem_word(32'h100));
    end
`endif
  endtask

  // Randomized run: the scoreboard queue holds the entries the unit should currently be buffering.
  task automatic test_random();
    logic [31:0] mpc;
    logic        mmis;
    logic        e_en;
    logic [63:0] e_head;
    apply_reset(1'($urandom_range(0, 1)));
    exp_q.delete();
    mpc = 32'h0;
    mmis = 1'b0;
    for (int c = 0; c < 400; c++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 7) == 0);
      redirect_pc = {$urandom_range(0, 255) == 0 ? 20'hFFFFF : 20'($urandom_range(0, 3)), 12'($urandom)};
      if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
      #1;
      e_head = (exp_q.size() != 0) ? exp_q[0] : 64'h0;
      e_en = !redirect_valid && !mmis && (exp_q.size() < 2 || (exp_q.size() != 0 && out_ready));
      checks++; if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", c, out_valid, exp_q.size() != 0); end
      checks++; if ({out_pc, out_inst} !== e_head) begin errors++; $display("FAIL rnd_head@%0d: got %h expected %h", c, {out_pc, out_inst}, e_head); end
      checks++; if (imem_rd_en !== e_en) begin errors++; $display("FAIL rnd_rd_en@%0d: got %b expected %b", c, imem_rd_en, e_en); end
      checks++; if (imem_addr !== mpc) begin errors++; $display("FAIL rnd_addr@%0d: got %h expected %h", c, imem_addr, mpc); end
      @(posedge clk);
      if (redirect_valid) begin
        exp_q.delete();
        mpc = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_CHECK_EN
        mmis = (redirect_pc % 4) != 0;
`endif
      end else begin
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (e_en) begin
          exp_q.push_back({mpc, mem_word(mpc)});
          mpc = mpc + 32'd4;
        end
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_ready();
    test_wrap();
    test_async_reset();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
